// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage RV32I pipeline: load-use bubbles, LSU wait stalls,
// mispredict redirect flushes, EX operand forwarding selects and a stall-cycle counter.
module hazard_unit #(
   parameter logic [1:0]  WB_SEL_LOAD = 2'b01,
   parameter int unsigned FLUSH_EXTRA = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [4:0]       i_rs1_addr_ID,
   input  logic [4:0]       i_rs2_addr_ID,
   input  logic [4:0]       i_rs1_addr_EX,
   input  logic [4:0]       i_rs2_addr_EX,
   input  logic [4:0]       i_rd_addr_EX,
   input  logic             i_rd_wren_EX,
   input  logic [1:0]       i_wb_sel_EX,
   input  logic [4:0]       i_rd_addr_MEM,
   input  logic             i_rd_wren_MEM,
   input  logic [4:0]       i_rd_addr_WB,
   input  logic             i_rd_wren_WB,
   input  logic             i_mispredict_EX,
   input  logic             i_lsu_req_MEM,
   input  logic             i_lsu_ready,
   output logic             stall_IF,
   output logic             stall_ID,
   output logic             stall_EX,
   output logic             flush_ID,
   output logic             flush_EX,
   output logic [1:0]       o_fwd_a_sel,
   output logic [1:0]       o_fwd_b_sel,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      REDIRECT = 2'b10
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_EXTRA);
   // With no extra flush cycles the redirect completes within the mispredict cycle itself.
   localparam state_t AFTER_FLUSH = (FLUSH_EXTRA == 0) ? RUN : REDIRECT;

   state_t           state_reg, state_next;
   logic [2:0]       flush_cnt_reg, flush_cnt_next;
   logic             pending_reg, pending_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic mem_wait;
   logic load_use;
   logic stall_if_next, stall_id_next, stall_ex_next;
   logic flush_id_next, flush_ex_next;

   // ------------------------------------------------------------------
   // Operand forwarding: the younger MEM result takes precedence over WB.
   // ------------------------------------------------------------------
   logic [4:0] rs_ex   [2];
   logic [1:0] fwd_sel [2];

   assign rs_ex[0] = i_rs1_addr_EX;
   assign rs_ex[1] = i_rs2_addr_EX;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         logic mem_hit;
         logic wb_hit;
         assign mem_hit = i_rd_wren_MEM && (i_rd_addr_MEM != 5'd0) && (i_rd_addr_MEM == rs_ex[gi]);
         assign wb_hit  = i_rd_wren_WB  && (i_rd_addr_WB  != 5'd0) && (i_rd_addr_WB  == rs_ex[gi]);
         assign fwd_sel[gi] = i_rst   ? 2'b00 :
                              mem_hit ? 2'b01 :
                              wb_hit  ? 2'b10 : 2'b00;
      end
   endgenerate

   assign o_fwd_a_sel = fwd_sel[0];
   assign o_fwd_b_sel = fwd_sel[1];

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   assign mem_wait = i_lsu_req_MEM && !i_lsu_ready;
   assign load_use = (i_wb_sel_EX == WB_SEL_LOAD) && i_rd_wren_EX && (i_rd_addr_EX != 5'd0) &&
                     ((i_rd_addr_EX == i_rs1_addr_ID) || (i_rd_addr_EX == i_rs2_addr_ID));

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      pending_next   = pending_reg;
      stall_if_next  = 1'b0;
      stall_id_next  = 1'b0;
      stall_ex_next  = 1'b0;
      flush_id_next  = 1'b0;
      flush_ex_next  = 1'b0;

      case (state_reg)
         RUN: begin
            if (mem_wait) begin
               stall_if_next = 1'b1;
               stall_id_next = 1'b1;
               stall_ex_next = 1'b1;
               pending_next  = pending_reg | i_mispredict_EX;
               state_next    = MEM_WAIT;
            end else if (i_mispredict_EX) begin
               flush_id_next  = 1'b1;
               flush_ex_next  = 1'b1;
               flush_cnt_next = FLUSH_INIT;
               state_next     = AFTER_FLUSH;
            end else if (load_use) begin
               // One bubble: hold IF/ID, inject a bubble into ID/EX.
               stall_if_next = 1'b1;
               stall_id_next = 1'b1;
               flush_ex_next = 1'b1;
            end
         end

         MEM_WAIT: begin
            if (mem_wait) begin
               stall_if_next = 1'b1;
               stall_id_next = 1'b1;
               stall_ex_next = 1'b1;
               pending_next  = pending_reg | i_mispredict_EX;
            end else if (pending_reg || i_mispredict_EX) begin
               flush_id_next  = 1'b1;
               flush_ex_next  = 1'b1;
               pending_next   = 1'b0;
               flush_cnt_next = FLUSH_INIT;
               state_next     = AFTER_FLUSH;
            end else begin
               state_next = RUN;
               // The held ID instruction advances this cycle, so a load-use still needs its bubble.
               if (load_use) begin
                  stall_if_next = 1'b1;
                  stall_id_next = 1'b1;
                  flush_ex_next = 1'b1;
               end
            end
         end

         REDIRECT: begin
            if (mem_wait) begin
               // Stalls win; the flush counter is frozen until the access completes.
               stall_if_next = 1'b1;
               stall_id_next = 1'b1;
               stall_ex_next = 1'b1;
               pending_next  = pending_reg | i_mispredict_EX;
            end else if (pending_reg || i_mispredict_EX) begin
               flush_id_next  = 1'b1;
               flush_ex_next  = 1'b1;
               pending_next   = 1'b0;
               flush_cnt_next = FLUSH_INIT;
            end else begin
               flush_id_next = 1'b1;
               if (flush_cnt_reg <= 3'd1) begin
                  state_next = RUN;
               end else begin
                  flush_cnt_next = flush_cnt_reg - 3'd1;
               end
            end
         end

         default: begin
            state_next = RUN;
         end
      endcase
   end

   // Reset silences every control output immediately, independent of the clock.
   assign stall_IF = stall_if_next & ~i_rst;
   assign stall_ID = stall_id_next & ~i_rst;
   assign stall_EX = stall_ex_next & ~i_rst;
   assign flush_ID = flush_id_next & ~i_rst;
   assign flush_EX = flush_ex_next & ~i_rst;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg     <= RUN;
         flush_cnt_reg <= 3'd0;
         pending_reg   <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
         pending_reg   <= pending_next;
         if (stall_IF && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
      end
   end

   assign o_state     = state_reg;
   assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
   logic        wren_ex, wren_mem, wren_wb;
   logic [1:0]  wb_sel_ex;
   logic        mispredict, lsu_req, lsu_ready;
   logic        stall_IF, stall_ID, stall_EX, flush_ID, flush_EX;
   logic [1:0]  fwd_a, fwd_b, state;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   hazard_unit #(
      .WB_SEL_LOAD (2'b01),
      .FLUSH_EXTRA (1),
      .CNT_W       (16)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_rs1_addr_ID   (rs1_id),
      .i_rs2_addr_ID   (rs2_id),
      .i_rs1_addr_EX   (rs1_ex),
      .i_rs2_addr_EX   (rs2_ex),
      .i_rd_addr_EX    (rd_ex),
      .i_rd_wren_EX    (wren_ex),
      .i_wb_sel_EX     (wb_sel_ex),
      .i_rd_addr_MEM   (rd_mem),
      .i_rd_wren_MEM   (wren_mem),
      .i_rd_addr_WB    (rd_wb),
      .i_rd_wren_WB    (wren_wb),
      .i_mispredict_EX (mispredict),
      .i_lsu_req_MEM   (lsu_req),
      .i_lsu_ready     (lsu_ready),
      .stall_IF        (stall_IF),
      .stall_ID        (stall_ID),
      .stall_EX        (stall_EX),
      .flush_ID        (flush_ID),
      .flush_EX        (flush_EX),
      .o_fwd_a_sel     (fwd_a),
      .o_fwd_b_sel     (fwd_b),
      .o_state         (state),
      .o_stall_cnt     (stall_cnt)
   );

   typedef struct {
      string       name;
      logic [4:0]  sf;   // {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX}
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [1:0]  st;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Monitor: one expectation per cycle, sampled half a period after the inputs change.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t        e;
         logic [4:0]  sf;
         e  = q.pop_front();
         sf = {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX};
         checks++;
         if (sf !== e.sf || fwd_a !== e.fa || fwd_b !== e.fb || state !== e.st || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s: got sf=%b fa=%b fb=%b st=%b cnt=%h, want sf=%b fa=%b fb=%b st=%b cnt=%h",
                     e.name, sf, fwd_a, fwd_b, state, stall_cnt, e.sf, e.fa, e.fb, e.st, e.cnt);
         end else begin
            $display("ok   %s: sf=%b fa=%b fb=%b st=%b cnt=%h", e.name, sf, fwd_a, fwd_b, state, stall_cnt);
         end
      end
   end

   task automatic clear_inputs();
      rs1_id = 5'd0; rs2_id = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
      rd_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
      wren_ex = 1'b0; wren_mem = 1'b0; wren_wb = 1'b0; wb_sel_ex = 2'b00;
      mispredict = 1'b0; lsu_req = 1'b0; lsu_ready = 1'b0;
   endtask

   // Queue the expectation for the cycle whose inputs were just applied, then move on.
   task automatic expect_cycle(input string name, input logic [4:0] sf, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [1:0] st, input logic [15:0] cnt);
      exp_t e;
      e.name = name; e.sf = sf; e.fa = fa; e.fb = fb; e.st = st; e.cnt = cnt;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;

      // Reset masks even a live load-use and forwarding match.
      wb_sel_ex = 2'b01; wren_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
      rd_mem = 5'd7; wren_mem = 1'b1; rs1_ex = 5'd7;
      expect_cycle("reset", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd0);

      rst = 1'b0; clear_inputs();
      expect_cycle("idle", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd0);

      // Load-use on rs2
      wb_sel_ex = 2'b01; wren_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd1; rs2_id = 5'd5;
      expect_cycle("load_use", 5'b11001, 2'b00, 2'b00, 2'b00, 16'd0);
      clear_inputs();
      expect_cycle("bubble", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd1);

      wb_sel_ex = 2'b01; wren_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
      expect_cycle("load_x0", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd1);
      wren_ex = 1'b0; rd_ex = 5'd5; rs1_id = 5'd5;
      expect_cycle("load_nowren", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd1);
      wb_sel_ex = 2'b00; wren_ex = 1'b1;
      expect_cycle("alu_dep", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd1);
      clear_inputs();

      // Forwarding
      rd_mem = 5'd7; wren_mem = 1'b1; rd_wb = 5'd7; wren_wb = 1'b1; rs1_ex = 5'd7; rs2_ex = 5'd3;
      expect_cycle("fwd_mem_wins", 5'b00000, 2'b01, 2'b00, 2'b00, 16'd1);
      rd_mem = 5'd0;
      expect_cycle("fwd_wb", 5'b00000, 2'b10, 2'b00, 2'b00, 16'd1);
      rd_mem = 5'd3; wren_mem = 1'b0; rd_wb = 5'd3;
      expect_cycle("fwd_b_wb", 5'b00000, 2'b00, 2'b10, 2'b00, 16'd1);
      wren_mem = 1'b1;
      expect_cycle("fwd_b_mem", 5'b00000, 2'b00, 2'b01, 2'b00, 16'd1);
      clear_inputs();

      // Mispredict with one extra flush cycle
      mispredict = 1'b1;
      expect_cycle("mispred_c0", 5'b00011, 2'b00, 2'b00, 2'b00, 16'd1);
      mispredict = 1'b0;
      expect_cycle("mispred_c1", 5'b00010, 2'b00, 2'b00, 2'b10, 16'd1);
      expect_cycle("mispred_c2", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd1);

      rst = 1'b1;
      expect_cycle("reset2", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd0);
      rst = 1'b0;

      // LSU wait with a mispredict arriving mid-wait
      lsu_req = 1'b1;
      expect_cycle("memw_c0", 5'b11100, 2'b00, 2'b00, 2'b00, 16'd0);
      mispredict = 1'b1;
      expect_cycle("memw_c1", 5'b11100, 2'b00, 2'b00, 2'b01, 16'd1);
      mispredict = 1'b0;
      expect_cycle("memw_c2", 5'b11100, 2'b00, 2'b00, 2'b01, 16'd2);
      lsu_ready = 1'b1;
      expect_cycle("memw_ready", 5'b00011, 2'b00, 2'b00, 2'b01, 16'd3);
      clear_inputs();
      expect_cycle("memw_redir", 5'b00010, 2'b00, 2'b00, 2'b10, 16'd3);
      expect_cycle("memw_run", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd3);

      // LSU wait arriving during REDIRECT
      mispredict = 1'b1;
      expect_cycle("rdw_c0", 5'b00011, 2'b00, 2'b00, 2'b00, 16'd3);
      mispredict = 1'b0; lsu_req = 1'b1;
      expect_cycle("rdw_c1", 5'b11100, 2'b00, 2'b00, 2'b10, 16'd3);
      expect_cycle("rdw_c2", 5'b11100, 2'b00, 2'b00, 2'b10, 16'd4);
      lsu_ready = 1'b1;
      wb_sel_ex = 2'b01; wren_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
      expect_cycle("rdw_ready", 5'b00010, 2'b00, 2'b00, 2'b10, 16'd5);
      clear_inputs();
      expect_cycle("rdw_run", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd5);

      // Asynchronous reset while in MEM_WAIT
      lsu_req = 1'b1;
      expect_cycle("arst_c0", 5'b11100, 2'b00, 2'b00, 2'b00, 16'd5);
      expect_cycle("arst_c1", 5'b11100, 2'b00, 2'b00, 2'b01, 16'd6);
      rst = 1'b1;
      expect_cycle("arst_hit", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd0);
      rst = 1'b0; clear_inputs();
      expect_cycle("arst_idle", 5'b00000, 2'b00, 2'b00, 2'b00, 16'd0);

      // Saturation of the stall counter
      lsu_req = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      expect_cycle("sat_c0", 5'b11100, 2'b00, 2'b00, 2'b01, 16'hFFFF);
      expect_cycle("sat_c1", 5'b11100, 2'b00, 2'b00, 2'b01, 16'hFFFF);
      lsu_ready = 1'b1;
      expect_cycle("sat_ready", 5'b00000, 2'b00, 2'b00, 2'b01, 16'hFFFF);
      clear_inputs();
      expect_cycle("sat_run", 5'b00000, 2'b00, 2'b00, 2'b00, 16'hFFFF);

      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
